// File: rtl/signed_calc_pkg.sv
// Shared constants and FSM encoding for the signed 6X - 11Y calculator slice.
package signed_calc_pkg;

   localparam int unsigned AS_W     = 5;
   localparam int unsigned FS_W     = 9;
   localparam int unsigned CALC_MAX = 15;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/signed_calc_v.sv
// Combinational 6X - 11Y datapath; result is 9-bit two's complement, wrapping modulo 512.
module signed_calc_v
   import signed_calc_pkg::*;
(
   input  logic [AS_W-1:0] i_as,
   input  logic [AS_W-1:0] i_bs,
   output logic [FS_W-1:0] o_fs
);

   logic [FS_W-1:0] xs;
   logic [FS_W-1:0] ys;
   logic [FS_W-1:0] p;
   logic [FS_W-1:0] q;
   logic            c;

   assign xs = {{(FS_W-AS_W){i_as[AS_W-1]}}, i_as};
   assign ys = {{(FS_W-AS_W){i_bs[AS_W-1]}}, i_bs};
   assign p  = (xs << 2) + (xs << 1);
   assign q  = (ys << 3) + (ys << 1) + ys;

   // p - q as a ripple chain: p + ~q with carry-in 1
   always_comb begin
      c    = 1'b1;
      o_fs = '0;
      for (int unsigned i = 0; i < FS_W; i++) begin
         o_fs[i] = p[i] ^ ~q[i] ^ c;
         c       = (p[i] & ~q[i]) | (c & (p[i] ^ ~q[i]));
      end
   end

endmodule

// File: rtl/signed_calc_arb_v.sv
// Two-requester round-robin front end sharing one signed_calc_v datapath.
module signed_calc_arb_v
   import signed_calc_pkg::*;
#(
   parameter int unsigned CALC_CYCLES = 2
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req0_vld,
   input  logic [AS_W-1:0] i_req0_as,
   input  logic [AS_W-1:0] i_req0_bs,
   output logic            o_req0_rdy,
   input  logic            i_req1_vld,
   input  logic [AS_W-1:0] i_req1_as,
   input  logic [AS_W-1:0] i_req1_bs,
   output logic            o_req1_rdy,
   output logic            o_rsp_vld,
   output logic            o_rsp_id,
   output logic [FS_W-1:0] o_rsp_fs,
   input  logic            i_rsp_rdy,
   output logic            o_busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic             prio;
   logic             gnt_id;
   logic             hs;
   logic             id_q;
   logic [CNT_W-1:0] cnt;
   logic [AS_W-1:0]  op_as;
   logic [AS_W-1:0]  op_bs;
   logic [FS_W-1:0]  calc_fs;
   logic [FS_W-1:0]  rsp_fs_q;
   logic             rsp_id_q;

   signed_calc_v u_calc (
      .i_as (op_as),
      .i_bs (op_bs),
      .o_fs (calc_fs)
   );

   always_comb begin
      state_nxt  = state;
      gnt_id     = (i_req0_vld && i_req1_vld) ? prio : i_req1_vld;
      o_req0_rdy = 1'b0;
      o_req1_rdy = 1'b0;
      case (state)
         IDLE: begin
            o_req0_rdy = i_req0_vld && !gnt_id;
            o_req1_rdy = i_req1_vld && gnt_id;
            if (o_req0_rdy || o_req1_rdy) state_nxt = CALC;
         end
         CALC: if (cnt == '0) state_nxt = RESP;
         RESP: if (i_rsp_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      hs = o_req0_rdy || o_req1_rdy;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         prio     <= 1'b0;
         cnt      <= '0;
         id_q     <= 1'b0;
         op_as    <= '0;
         op_bs    <= '0;
         rsp_fs_q <= '0;
         rsp_id_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            op_as <= gnt_id ? i_req1_as : i_req0_as;
            op_bs <= gnt_id ? i_req1_bs : i_req0_bs;
            id_q  <= gnt_id;
            cnt   <= CNT_LOAD;
         end
         if (state == CALC) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               rsp_fs_q <= calc_fs;
               rsp_id_q <= id_q;
            end
         end
         // pointer moves only once a response has been consumed
         if (state == RESP && i_rsp_rdy) prio <= ~rsp_id_q;
      end
   end

   assign o_rsp_vld = (state == RESP);
   assign o_rsp_id  = rsp_id_q;
   assign o_rsp_fs  = rsp_fs_q;
   assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_signed_calc_arb_v.sv
// Directed bench for signed_calc_arb_v; instances with CALC_CYCLES = 2, 1 and 15.
module tb_signed_calc_arb_v;

   logic       clk;
   logic       rst;
   logic       vld0[3];
   logic       vld1[3];
   logic       rdy0[3];
   logic       rdy1[3];
   logic [4:0] as0[3];
   logic [4:0] bs0[3];
   logic [4:0] as1[3];
   logic [4:0] bs1[3];
   logic       rsp_vld[3];
   logic       rsp_id[3];
   logic [8:0] fs[3];
   logic       rsp_rdy[3];
   logic       busy[3];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      signed_calc_arb_v #(.CALC_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
         .i_clk      (clk),
         .i_rst      (rst),
         .i_req0_vld (vld0[g]),
         .i_req0_as  (as0[g]),
         .i_req0_bs  (bs0[g]),
         .o_req0_rdy (rdy0[g]),
         .i_req1_vld (vld1[g]),
         .i_req1_as  (as1[g]),
         .i_req1_bs  (bs1[g]),
         .o_req1_rdy (rdy1[g]),
         .o_rsp_vld  (rsp_vld[g]),
         .o_rsp_id   (rsp_id[g]),
         .o_rsp_fs   (fs[g]),
         .i_rsp_rdy  (rsp_rdy[g]),
         .o_busy     (busy[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [8:0] model_fs(input int a, input int b);
      int r;
      r = 6 * a - 11 * b;
      return r[8:0];
   endfunction

   task automatic set_req(input int k, input int id, input logic v, input int a, input int b);
      if (id == 0) begin
         vld0[k] = v; as0[k] = a[4:0]; bs0[k] = b[4:0];
      end else begin
         vld1[k] = v; as1[k] = a[4:0]; bs1[k] = b[4:0];
      end
   endtask

   task automatic wait_rsp(input int k, output int lat, output logic [8:0] f, output logic rid);
      lat = 0;
      while (!rsp_vld[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      f   = fs[k];
      rid = rsp_id[k];
   endtask

   task automatic ack(input int k);
      rsp_rdy[k] = 1'b1;
      @(posedge clk); #1;
      rsp_rdy[k] = 1'b0;
   endtask

   task automatic run_txn(input int k, input int id, input int a, input int b,
                          output int lat, output logic [8:0] f, output logic rid);
      int w;
      w = 0;
      set_req(k, id, 1'b1, a, b);
      #1;
      while (!(id == 0 ? rdy0[k] : rdy1[k]) && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 40) begin
         set_req(k, id, 1'b0, a, b);
         lat = -1; f = 'x; rid = 'x;
         return;
      end
      @(posedge clk); #1;
      set_req(k, id, 1'b0, a, b);
      wait_rsp(k, lat, f, rid);
      ack(k);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_req(k, 0, 1'b0, 0, 0);
         set_req(k, 1, 1'b0, 0, 0);
         rsp_rdy[k] = 1'b0;
      end
      #3;
      chk_cnt++; if (rsp_vld[0] !== 1'b0) $display("FAIL reset_rsp_vld got %b exp 0", rsp_vld[0]); else pass_cnt++;
      chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy[0]); else pass_cnt++;
      chk_cnt++; if (fs[0] !== 9'h000) $display("FAIL reset_fs got %h exp 000", fs[0]); else pass_cnt++;
      chk_cnt++; if (rsp_id[0] !== 1'b0) $display("FAIL reset_id got %b exp 0", rsp_id[0]); else pass_cnt++;
      vld1[0] = 1'b1;
      #1;
      chk_cnt++; if (rdy1[0] !== 1'b1 || rdy0[0] !== 1'b0) $display("FAIL reset_lone_rdy got %b%b exp 10", rdy1[0], rdy0[0]); else pass_cnt++;
      vld0[0] = 1'b1;
      #1;
      chk_cnt++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) $display("FAIL reset_both_rdy got %b%b exp 01", rdy1[0], rdy0[0]); else pass_cnt++;
      vld0[0] = 1'b0;
      vld1[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int lat; logic [8:0] f; logic rid;
      run_txn(0, 0, 5, 3, lat, f, rid);
      chk_cnt++; if (lat != 2) $display("FAIL single_latency got %0d exp 2", lat); else pass_cnt++;
      chk_cnt++; if (f !== 9'h1FD) $display("FAIL single_fs got %h exp 1fd", f); else pass_cnt++;
      chk_cnt++; if (rid !== 1'b0) $display("FAIL single_id got %b exp 0", rid); else pass_cnt++;
   endtask

   task automatic test_contention();
      int lat; logic [8:0] f; logic rid;
      do_reset();
      set_req(0, 0, 1'b1, 1, 0);
      set_req(0, 1, 1'b1, 0, 1);
      #1;
      chk_cnt++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) $display("FAIL cont_first_grant got %b%b exp 01", rdy1[0], rdy0[0]); else pass_cnt++;
      @(posedge clk); #1;
      set_req(0, 0, 1'b0, 1, 0);
      chk_cnt++; if (rdy1[0] !== 1'b0) $display("FAIL cont_rdy_in_calc got %b exp 0", rdy1[0]); else pass_cnt++;
      wait_rsp(0, lat, f, rid);
      chk_cnt++; if (rid !== 1'b0 || f !== 9'h006) $display("FAIL cont_first_rsp got id %b fs %h exp id 0 fs 006", rid, f); else pass_cnt++;
      ack(0);
      set_req(0, 0, 1'b1, 2, 2);
      #1;
      chk_cnt++; if (rdy1[0] !== 1'b1 || rdy0[0] !== 1'b0) $display("FAIL cont_second_grant got %b%b exp 10", rdy1[0], rdy0[0]); else pass_cnt++;
      @(posedge clk); #1;
      set_req(0, 1, 1'b0, 0, 1);
      wait_rsp(0, lat, f, rid);
      chk_cnt++; if (rid !== 1'b1 || f !== 9'h1F5) $display("FAIL cont_second_rsp got id %b fs %h exp id 1 fs 1f5", rid, f); else pass_cnt++;
      ack(0);
      #1;
      chk_cnt++; if (rdy0[0] !== 1'b1) $display("FAIL cont_pending_grant got %b exp 1", rdy0[0]); else pass_cnt++;
      @(posedge clk); #1;
      set_req(0, 0, 1'b0, 2, 2);
      wait_rsp(0, lat, f, rid);
      chk_cnt++; if (rid !== 1'b0 || f !== 9'h1F6) $display("FAIL cont_third_rsp got id %b fs %h exp id 0 fs 1f6", rid, f); else pass_cnt++;
      ack(0);
   endtask

   task automatic test_wrap();
      int ta[3] = '{-16, 15, -1};
      int tb[3] = '{15, -16, -1};
      logic [8:0] te[3] = '{9'h0FB, 9'h10A, 9'h005};
      int lat; logic [8:0] f; logic rid;
      for (int n = 0; n < 3; n++) begin
         run_txn(0, n % 2, ta[n], tb[n], lat, f, rid);
         chk_cnt++; if (f !== te[n]) $display("FAIL wrap_fs[%0d] got %h exp %h", n, f, te[n]); else pass_cnt++;
         chk_cnt++; if (lat != 2 || rid !== 1'(n % 2)) $display("FAIL wrap_lat_id[%0d] got lat %0d id %b exp lat 2 id %0d", n, lat, rid, n % 2); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [8:0] f; logic rid;
      set_req(0, 0, 1'b1, 3, -2);
      #1;
      @(posedge clk); #1;
      set_req(0, 0, 1'b0, 3, -2);
      wait_rsp(0, lat, f, rid);
      chk_cnt++; if (lat != 2) $display("FAIL bp_latency got %0d exp 2", lat); else pass_cnt++;
      set_req(0, 1, 1'b1, -3, 2);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk_cnt++;
         if (rsp_vld[0] !== 1'b1 || fs[0] !== 9'h028 || rsp_id[0] !== 1'b0 || rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0)
            $display("FAIL bp_hold[%0d] got vld %b fs %h id %b rdy %b%b exp vld 1 fs 028 id 0 rdy 00",
                     c, rsp_vld[0], fs[0], rsp_id[0], rdy1[0], rdy0[0]);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      ack(0);
      #1;
      chk_cnt++; if (rsp_vld[0] !== 1'b0 || rdy1[0] !== 1'b1) $display("FAIL bp_release got vld %b rdy1 %b exp vld 0 rdy1 1", rsp_vld[0], rdy1[0]); else pass_cnt++;
      @(posedge clk); #1;
      set_req(0, 1, 1'b0, -3, 2);
      wait_rsp(0, lat, f, rid);
      chk_cnt++; if (f !== 9'h1D8 || rid !== 1'b1) $display("FAIL bp_pending_rsp got fs %h id %b exp fs 1d8 id 1", f, rid); else pass_cnt++;
      ack(0);
   endtask

   task automatic test_reset_mid_calc();
      int lat; logic [8:0] f; logic rid;
      logic seen;
      run_txn(0, 0, 1, 1, lat, f, rid);
      chk_cnt++; if (f !== 9'h1FB) $display("FAIL rmc_pre_fs got %h exp 1fb", f); else pass_cnt++;
      set_req(0, 1, 1'b1, 4, 4);
      #1;
      @(posedge clk); #1;
      set_req(0, 1, 1'b0, 4, 4);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_cnt++; if (rsp_vld[0] !== 1'b0 || busy[0] !== 1'b0) $display("FAIL rmc_async got vld %b busy %b exp 0 0", rsp_vld[0], busy[0]); else pass_cnt++;
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         seen = seen | rsp_vld[0] | busy[0];
      end
      chk_cnt++; if (seen !== 1'b0) $display("FAIL rmc_no_rsp got %b exp 0", seen); else pass_cnt++;
      set_req(0, 0, 1'b1, 0, 0);
      set_req(0, 1, 1'b1, 0, 0);
      #1;
      chk_cnt++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) $display("FAIL rmc_prio got %b%b exp 01", rdy1[0], rdy0[0]); else pass_cnt++;
      set_req(0, 0, 1'b0, 0, 0);
      set_req(0, 1, 1'b0, 0, 0);
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      int lat; logic [8:0] f; logic rid;
      int a, b, exp_lat;
      for (int k = 1; k < 3; k++) begin
         exp_lat = (k == 1) ? 1 : 15;
         for (int n = 0; n < 4; n++) begin
            a = int'($urandom_range(31)) - 16;
            b = int'($urandom_range(31)) - 16;
            run_txn(k, n % 2, a, b, lat, f, rid);
            chk_cnt++; if (lat != exp_lat) $display("FAIL lat_c%0d[%0d] got %0d exp %0d", exp_lat, n, lat, exp_lat); else pass_cnt++;
            chk_cnt++; if (f !== model_fs(a, b)) $display("FAIL fs_c%0d[%0d] a=%0d b=%0d got %h exp %h", exp_lat, n, a, b, f, model_fs(a, b)); else pass_cnt++;
            chk_cnt++; if (rid !== 1'(n % 2)) $display("FAIL id_c%0d[%0d] got %b exp %0d", exp_lat, n, rid, n % 2); else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_backpressure();
      test_reset_mid_calc();
      test_latency();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/signed_calc_arb_v.md
# signed_calc_arb_v

Two-requester round-robin front end for one shared `signed_calc_v` datapath, which computes 6X − 11Y. Each requester hands over a pair of 5-bit signed operands with a valid/ready handshake. The block registers the operands into the single datapath instance and waits a programmable settle time for the ripple-carry chain. It then captures the 9-bit signed result and returns it on one response channel, tagged with the requester ID.

## Interface
Parameters:
- `CALC_CYCLES`, default 2: cycles the operands are held on the datapath before the result is captured. Legal range 1..15.

Ports:
- `i_clk`, input, 1: system clock. All state is updated on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_req0_vld`, input, 1: requester 0 is offering an operand pair.
- `i_req0_as`, input, 5 (signed): requester 0 operand X.
- `i_req0_bs`, input, 5 (signed): requester 0 operand Y.
- `o_req0_rdy`, output, 1: the block accepts requester 0 this cycle.
- `i_req1_vld`, `i_req1_as`, `i_req1_bs`, `o_req1_rdy`: same as above, for requester 1.
- `o_rsp_vld`, output, 1: a result is held and presented.
- `o_rsp_id`, output, 1: ID of the requester that owns the result.
- `o_rsp_fs`, output, 9 (signed): the result 6X − 11Y.
- `i_rsp_rdy`, input, 1: the consumer accepts the result.
- `o_busy`, output, 1: high when the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, CALC and RESP.
- **IDLE**
  - Grant: if both `vld` are high, the requester selected by the priority pointer `prio` wins. Otherwise the single valid requester wins.
  - `o_reqN_rdy` is high only for the granted requester, and only in IDLE. It is combinational from the `vld` inputs and `prio`.
  - Requesters must not make `vld` depend on `rdy`.
  - On a handshake (`vld` and `rdy` both high):
    - register `as`/`bs` into the operand register feeding `signed_calc_v`;
    - register the grant ID;
    - load the counter with `CALC_CYCLES`−1;
    - move to CALC.
- **CALC**
  - While the counter is nonzero, decrement it each cycle.
  - When the counter is 0, capture the datapath output into `o_rsp_fs` and the registered ID into `o_rsp_id`. Move to RESP.
- **RESP**
  - `o_rsp_vld` is high. `o_rsp_fs` and `o_rsp_id` are held stable while `i_rsp_rdy` is low.
  - On `i_rsp_rdy`, deassert `o_rsp_vld` and return to IDLE. Set `prio` to the requester that was not just served.
  - No new request is accepted in RESP.
- **Arithmetic**
  - The result is 9-bit two's complement, modulo 512, exactly as the datapath produces it.
  - The true range is −261..266. Values outside −256..255 wrap silently. There is no saturation and no overflow flag.
- **Fairness**: the priority pointer alternates only after a completed response. A lone requester may be served back-to-back.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `prio` = 0, counter = 0;
  - `o_rsp_vld` = 0, `o_rsp_id` = 0, `o_rsp_fs` = 9'h000, `o_busy` = 0;
  - operand register = 0;
  - `o_req0_rdy` and `o_req1_rdy` follow IDLE rules: high if the corresponding `vld` is high and that requester is granted.
- Latency: with the handshake at edge T, `o_rsp_vld` rises after edge T+`CALC_CYCLES`.
- Throughput: with `i_rsp_rdy` tied high, at most one result every `CALC_CYCLES`+2 cycles.
- Reset mid-operation: the in-flight request and any held result are discarded, and `o_rsp_vld` drops immediately.
- Simultaneous events: both `vld` high in IDLE gives exactly one `rdy`, never both.

## Structure
- Shared package `signed_calc_pkg` holds:
  - the state encoding (IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2);
  - the width constants `AS_W` = 5 and `FS_W` = 9;
  - the maximum legal `CALC_CYCLES` (15).
- There is one sub-module: `signed_calc_v`, instantiated unchanged and fed from the operand register. Arbiter, counter and FSM live in this block.

## Test plan
- Single request: req0 with as=5, bs=3 and `CALC_CYCLES`=2 → `o_rsp_fs`=9'h1FD (−3) and `o_rsp_id`=0, with `o_rsp_vld` rising 2 edges after the handshake.
- Contention: req0 and req1 both valid from reset → req0 is served first, then req1. A second simultaneous pair → req1 is served first.
- Wrap:
  - as=−16, bs=15 → 9'h0FB (−261 wrapped).
  - as=15, bs=−16 → 9'h10A (266 wrapped).
  - as=−1, bs=−1 → 9'h005.
- Backpressure: `i_rsp_rdy` held low for 5 cycles in RESP → result and ID stay stable, both `rdy` stay low, and a new request stays pending until release.
- Reset mid-CALC: assert `i_rst` one cycle after the handshake → `o_rsp_vld` stays 0, state returns to IDLE, `prio`=0, and no response is ever produced for that request.
- `CALC_CYCLES`=1 and 15 → results match 6X − 11Y mod 512 over random operands, with latency 1 and 15 respectively.
